// File: rtl/mux3_1_checked.sv
// rtl/mux3_1_checked.sv - registered 3:1 selector with dual-path consistency check
// Path A (assign) drives Y; path B (procedural case) only feeds the comparator.
module mux3_1_checked #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] FAULT_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             S0,
  input  logic             S1,
  input  logic             in_valid,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_count
);

  logic [WIDTH-1:0] path_a;
  logic [WIDTH-1:0] path_b;
  logic             disagree;

  assign path_a = S1 ? D2 : (S0 ? D1 : D0);

  // FAULT_MASK is zero in normal use; a nonzero mask corrupts path B to exercise the checker.
  always_comb begin
    path_b = D0;
    case ({S1, S0})
      2'b00:   path_b = D0;
      2'b01:   path_b = D1;
      2'b10:   path_b = D2;
      2'b11:   path_b = D2;
      default: path_b = D0;
    endcase
    path_b = path_b ^ FAULT_MASK;
  end

  assign disagree = (path_a != path_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Y <= path_a;
    end
  end

  // clr_err wins over a same-cycle disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch       <= 1'b0;
      mismatch_count <= '0;
    end else if (clr_err) begin
      mismatch       <= 1'b0;
      mismatch_count <= '0;
    end else if (in_valid && disagree) begin
      mismatch <= 1'b1;
      if (mismatch_count != {CNT_W{1'b1}}) mismatch_count <= mismatch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux3_1_checked.sv
// tb/tb_mux3_1_checked.sv - randomized self-checking bench for mux3_1_checked
// Three instances: 8-bit, 1-bit, and a 1-bit copy with path B corrupted and CNT_W=2.
module tb_mux3_1_checked;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic       s0 = 1'b0, s1 = 1'b0, iv = 1'b0, clr = 1'b0;
  logic       fv = 1'b0, fclr = 1'b0;

  logic [7:0] y8;
  logic       ov8, mm8;
  logic [7:0] cnt8;
  logic       y1, ov1, mm1;
  logic [7:0] cnt1;
  logic       yf, ovf, mmf;
  logic [1:0] cntf;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mux3_1_checked #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .D0(d0), .D1(d1), .D2(d2), .S0(s0), .S1(s1),
    .in_valid(iv), .clr_err(clr), .Y(y8), .out_valid(ov8), .mismatch(mm8),
    .mismatch_count(cnt8));

  mux3_1_checked #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .D0(d0[0]), .D1(d1[0]), .D2(d2[0]), .S0(s0), .S1(s1),
    .in_valid(iv), .clr_err(clr), .Y(y1), .out_valid(ov1), .mismatch(mm1),
    .mismatch_count(cnt1));

  mux3_1_checked #(.WIDTH(1), .CNT_W(2), .FAULT_MASK(1'b1)) dutf (
    .clk(clk), .rst(rst), .D0(d0[0]), .D1(d1[0]), .D2(d2[0]), .S0(s0), .S1(s1),
    .in_valid(fv), .clr_err(fclr), .Y(yf), .out_valid(ovf), .mismatch(mmf),
    .mismatch_count(cntf));

  function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    logic [7:0] tbl [4];
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = c;
    return tbl[s];
  endfunction

  // Reference state: what each output must hold after the most recent edge.
  logic [7:0] m_y = '0;
  logic       m_ov = 1'b0;
  logic       m_fy = 1'b0;
  logic       m_fov = 1'b0;
  int         m_fcnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_y <= '0; m_ov <= 1'b0; m_fy <= 1'b0; m_fov <= 1'b0; m_fcnt <= 0;
    end else begin
      m_ov  <= iv;
      if (iv) m_y <= pick({s1, s0}, d0, d1, d2);
      m_fov <= fv;
      if (fv) m_fy <= pick({s1, s0}, d0, d1, d2) & 8'h01;
      if (fclr) m_fcnt <= 0;
      else if (fv) m_fcnt <= (m_fcnt + 1 > 3) ? 3 : m_fcnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("y8", 32'(y8), 32'(m_y));
    check("ov8", 32'(ov8), 32'(m_ov));
    check("y1", 32'(y1), 32'(m_y[0]));
    check("ov1", 32'(ov1), 32'(m_ov));
    check("mm8", 32'(mm8), 0);
    check("cnt8", 32'(cnt8), 0);
    check("mm1", 32'(mm1), 0);
    check("cnt1", 32'(cnt1), 0);
    check("yf", 32'(yf), 32'(m_fy));
    check("ovf", 32'(ovf), 32'(m_fov));
    check("cntf", 32'(cntf), 32'(m_fcnt));
    check("mmf", 32'(mmf), 32'(m_fcnt != 0));
  end

  task automatic beat(input logic v, input logic [1:0] s, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    iv = v; {s1, s0} = s; d0 = a; d1 = b; d2 = c;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_y"}, 32'({y8, y1}), 0);
    check({tag, "_ov"}, 32'({ov8, ov1, ovf}), 0);
    check({tag, "_mm"}, 32'({mmf, cntf}), 0);
  endtask

  initial begin
    logic [7:0] pat_y [2][4];
    pat_y[0] = '{8'h01, 8'h00, 8'h01, 8'h01};
    pat_y[1] = '{8'h00, 8'h01, 8'h00, 8'h00};

    // Async reset between edges
    @(negedge clk); #2 rst = 1'b1; #1;
    check_zero("rst_async");
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("idle");

    // Exhaustive select, two data patterns
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 4; s++) begin
        beat(1'b1, 2'(s), (p == 0) ? 8'h01 : 8'h00, (p == 0) ? 8'h00 : 8'h01,
             (p == 0) ? 8'h01 : 8'h00);
        @(negedge clk);
        check("exh_y", 32'(y1), 32'(pat_y[p][s][0]));
        check("exh_ov", 32'(ov1), 1);
        iv = 1'b0;
      end
    end

    // Random stress
    for (int i = 0; i < 100; i++)
      beat(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
    @(negedge clk);
    check("stress_mm", 32'({mm8, mm1}), 0);
    check("stress_cnt", 32'({cnt8, cnt1}), 0);

    // Hold with in_valid low while inputs toggle
    beat(1'b1, 2'b01, 8'h00, 8'h01, 8'h00);
    for (int i = 0; i < 2; i++) beat(1'b0, 2'(i + 2), 8'hff, 8'h00, 8'h00);
    @(negedge clk);
    check("hold_y", 32'(y1), 1);
    check("hold_ov", 32'(ov1), 0);

    // Error path on the fault-injected instance
    repeat (2) begin @(negedge clk); fv = 1'b1; end
    @(negedge clk); fv = 1'b0;
    check("err_mm", 32'(mmf), 1);
    check("err_cnt", 32'(cntf), 2);
    fclr = 1'b1; @(negedge clk); fclr = 1'b0;
    check("clr_cnt", 32'({mmf, cntf}), 0);
    repeat (5) begin fv = 1'b1; @(negedge clk); end
    fv = 1'b0;
    check("sat_cnt", 32'(cntf), 3);
    fv = 1'b1; fclr = 1'b1; @(negedge clk); fv = 1'b0; fclr = 1'b0;
    check("clr_prio", 32'({mmf, cntf}), 0);

    // Async reset during random traffic, then recovery
    for (int i = 0; i < 10; i++)
      beat(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
    #2 rst = 1'b1; #1;
    check_zero("rst_mid");
    #1 rst = 1'b0;
    beat(1'b1, 2'b10, 8'h11, 8'h22, 8'h5a);
    @(negedge clk);
    iv = 1'b0;
    check("post_rst_y", 32'(y8), 32'h5a);
    check("post_rst_ov", 32'(ov8), 1);
    for (int i = 0; i < 20; i++)
      beat(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux3_1_checked.md
Name: mux3_1_checked

Overview:
- Registered 3:1 selector with built-in self-check. Combines the behaviour of the existing mux3_1_assign and mux3_1_always blocks.
- Computes the selection twice, in two independent internal paths:
  - continuous-assignment path;
  - procedural combinational path.
- Registers the result and flags any disagreement between the two paths.
- Sits in datapaths where a small data-select needs a registered output plus a redundancy/consistency check.

Parameters:
- WIDTH, 1, bit width of D0, D1, D2 and Y.
- CNT_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- D0  input  WIDTH  data input 0
- D1  input  WIDTH  data input 1
- D2  input  WIDTH  data input 2
- S0  input  1  select bit 0 (LSB)
- S1  input  1  select bit 1 (MSB)
- in_valid  input  1  qualifies D0/D1/D2/S0/S1 this cycle
- clr_err  input  1  synchronous clear of error status
- Y  output  WIDTH  registered selected data
- out_valid  output  1  Y holds a result sampled from a valid input
- mismatch  output  1  sticky: the two internal paths disagreed at least once
- mismatch_count  output  CNT_W  number of valid cycles with disagreement, saturating

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Select function, identical in both internal paths:
  - {S1,S0}=00 -> D0
  - 01 -> D1
  - 10 -> D2
  - 11 -> D2 (S1 dominates)
  - Equivalently: Y_next = S1 ? D2 : (S0 ? D1 : D0).
- Path A: continuous conditional assignment.
- Path B: combinational procedural block with a full case on {S1,S0}, a default branch, and no inferred latches.
- Reset (asynchronous, rst=1), applied immediately regardless of clk:
  - Y=0, out_valid=0, mismatch=0, mismatch_count=0.
  - Reset asserted mid-operation discards any in-flight result.
- Latency: 1 cycle. On a rising clk edge with in_valid=1:
  - Y <= path A result;
  - out_valid <= 1.
- On a rising clk edge with in_valid=0:
  - Y holds its previous value;
  - out_valid <= 0.
- Mismatch detection is evaluated only on rising edges with in_valid=1. If path A != path B (bitwise, full WIDTH):
  - mismatch <= 1;
  - mismatch_count increments by 1, saturating at 2^CNT_W-1 with no wrap.
- clr_err=1 on a rising edge:
  - mismatch <= 0 and mismatch_count <= 0.
  - clr_err takes priority over a same-cycle mismatch, so the clear wins.
  - Y and out_valid are unaffected.
- X/Z on select or data inputs is not required to be handled. The outputs must be deterministic for all 0/1 combinations.
- In a correct implementation, mismatch stays 0 for all inputs.

Test Plan:
- Reset:
  - assert rst between clock edges -> Y=0, out_valid=0, mismatch=0, mismatch_count=0 immediately;
  - release, then idle 3 cycles -> all outputs remain 0.
- Exhaustive select, WIDTH=1:
  - apply D0=1, D1=0, D2=1 with all four {S1,S0}, in_valid=1 -> Y one cycle later = 1, 0, 1, 1 respectively, out_valid=1.
  - Repeat with D0=0, D1=1, D2=0 -> Y = 0, 1, 0, 0.
- Random stress:
  - 100 cycles of random D0/D1/D2/S0/S1, in_valid=1 -> each Y matches S1?D2:(S0?D1:D0) of the previous cycle;
  - mismatch=0 and mismatch_count=0 at the end.
- Hold:
  - valid beat with S=01, D1=1, then in_valid=0 for 2 cycles while inputs toggle -> Y stays 1, out_valid=0.
- Error path, using a fault-injected path B:
  - 2 disagreeing valid cycles -> mismatch=1, mismatch_count=2;
  - clr_err pulse -> both return to 0;
  - CNT_W=2 with 5 faulty cycles -> count saturates at 3.
- Async reset mid-stream:
  - rst pulse between edges during random traffic -> outputs zero at once;
  - first valid beat after release produces a correct Y one cycle later.
